// File: rtl/gate_fault_arbiter.sv
// Round-robin arbiter sharing one faulty-gate evaluator between requesters.
// Define FAULT_ARB_STATS_EN to add saturating eval_count/true_count outputs.
module gate_fault_arbiter #(
   parameter int REQ_COUNT    = 4,
   parameter int INPUT_COUNT  = 2,
   parameter int EVAL_LATENCY = 1,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                             clk,
   input  logic                             logic_reset_n,
   input  logic [REQ_COUNT-1:0]             req,
   input  logic [REQ_COUNT*INPUT_COUNT-1:0] req_in,
   output logic [REQ_COUNT-1:0]             ack,
   output logic                             ack_result,
   output logic                             busy,
   output logic [INPUT_COUNT-1:0]           gate_in,
   output logic                             gate_fault_in,
   input  logic                             gate_out
`ifdef FAULT_ARB_STATS_EN
   ,
   output logic [CNT_WIDTH-1:0]             eval_count,
   output logic [CNT_WIDTH-1:0]             true_count
`endif
);

   localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
   localparam int CW = $clog2(EVAL_LATENCY + 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   state_e                 state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [REQ_COUNT-1:0]   ack_q, ack_d;
   logic                   ack_result_q, ack_result_d;
   logic                   busy_q, busy_d;
   logic [INPUT_COUNT-1:0] gate_in_q, gate_in_d;
   logic                   fault_q, fault_d;

   logic                   grant_found;
   logic [IW-1:0]          grant_idx;
   logic [INPUT_COUNT-1:0] grant_vec;
   logic [REQ_COUNT-1:0]   idx_onehot;

   // Search ptr+1, ptr+2, ... so the last winner has lowest priority.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_vec   = '0;
      for (int i = 1; i <= REQ_COUNT; i++) begin
         for (int k = 0; k < REQ_COUNT; k++) begin
            if (!grant_found && req[k] &&
                k == (int'(ptr_q) + i) % REQ_COUNT) begin
               grant_found = 1'b1;
               grant_idx   = IW'(k);
               grant_vec   = req_in[k*INPUT_COUNT +: INPUT_COUNT];
            end
         end
      end
   end

   always_comb begin
      idx_onehot = '0;
      for (int k = 0; k < REQ_COUNT; k++) begin
         idx_onehot[k] = (IW'(k) == idx_q);
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      ack_d        = '0;
      ack_result_d = ack_result_q;
      gate_in_d    = gate_in_q;
      fault_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            gate_in_d = '0;
            if (grant_found) begin
               idx_d     = grant_idx;
               gate_in_d = grant_vec;
               fault_d   = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CW'(EVAL_LATENCY);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CW'(1)) begin
               ack_result_d = gate_out;
               ack_d        = idx_onehot;
               state_d      = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            ptr_d     = idx_q;
            gate_in_d = '0;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

`ifdef FAULT_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] eval_q, eval_d;
   logic [CNT_WIDTH-1:0] true_q, true_d;

   always_comb begin
      eval_d = eval_q;
      true_d = true_q;
      if (state_q == RESP) begin
         if (eval_q != '1) begin
            eval_d = eval_q + 1'b1;
         end
         if (ack_result_q && true_q != '1) begin
            true_d = true_q + 1'b1;
         end
      end
   end

   assign eval_count = eval_q;
   assign true_count = true_q;
`endif

   always_ff @(posedge clk or negedge logic_reset_n) begin
      if (!logic_reset_n) begin
         state_q      <= IDLE;
         ptr_q        <= IW'(REQ_COUNT - 1);
         idx_q        <= '0;
         cnt_q        <= '0;
         ack_q        <= '0;
         ack_result_q <= 1'b0;
         busy_q       <= 1'b0;
         gate_in_q    <= '0;
         fault_q      <= 1'b0;
`ifdef FAULT_ARB_STATS_EN
         eval_q       <= '0;
         true_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         ack_q        <= ack_d;
         ack_result_q <= ack_result_d;
         busy_q       <= busy_d;
         gate_in_q    <= gate_in_d;
         fault_q      <= fault_d;
`ifdef FAULT_ARB_STATS_EN
         eval_q       <= eval_d;
         true_q       <= true_d;
`endif
      end
   end

   assign ack           = ack_q;
   assign ack_result    = ack_result_q;
   assign busy          = busy_q;
   assign gate_in       = gate_in_q;
   assign gate_fault_in = fault_q;

endmodule

// File: tb/tb_gate_fault_arbiter.sv
// Bench for gate_fault_arbiter: two instances (latency 1 and 2),
// directed scenarios plus a randomized run against a schedule model.
module tb_gate_fault_arbiter;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0][3:0] req;
   logic [1:0][7:0] req_in;
   logic [1:0][3:0] ack;
   logic [1:0]      ack_result;
   logic [1:0]      busy;
   logic [1:0][1:0] gate_in;
   logic [1:0]      gate_fault_in;
   logic [1:0]      gate_out;
   logic [1:0][3:0] lut;
`ifdef FAULT_ARB_STATS_EN
   logic [1:0][2:0] eval_count;
   logic [1:0][2:0] true_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Behavioural faulty gate: truth table lookup on the presented inputs.
   assign gate_out[0] = lut[0][gate_in[0]];
   assign gate_out[1] = lut[1][gate_in[1]];

   gate_fault_arbiter #(
      .REQ_COUNT(4), .INPUT_COUNT(2), .EVAL_LATENCY(1), .CNT_WIDTH(3)
   ) u0 (
      .clk(clk), .logic_reset_n(rst_n),
      .req(req[0]), .req_in(req_in[0]),
      .ack(ack[0]), .ack_result(ack_result[0]), .busy(busy[0]),
      .gate_in(gate_in[0]), .gate_fault_in(gate_fault_in[0]),
      .gate_out(gate_out[0])
`ifdef FAULT_ARB_STATS_EN
      , .eval_count(eval_count[0]), .true_count(true_count[0])
`endif
   );

   gate_fault_arbiter #(
      .REQ_COUNT(4), .INPUT_COUNT(2), .EVAL_LATENCY(2), .CNT_WIDTH(3)
   ) u1 (
      .clk(clk), .logic_reset_n(rst_n),
      .req(req[1]), .req_in(req_in[1]),
      .ack(ack[1]), .ack_result(ack_result[1]), .busy(busy[1]),
      .gate_in(gate_in[1]), .gate_fault_in(gate_fault_in[1]),
      .gate_out(gate_out[1])
`ifdef FAULT_ARB_STATS_EN
      , .eval_count(eval_count[1]), .true_count(true_count[1])
`endif
   );

   function automatic int lat(input int u);
      return (u == 0) ? 1 : 2;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_ack(input int u, input int budget,
                           output logic [3:0] a, output int cyc);
      a = '0;
      cyc = 0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (a == 4'b0 && ack[u] != 4'b0) begin
            a = ack[u];
            cyc = c;
            c = budget;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req = '1;
      req_in = 16'($urandom);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         for (int u = 0; u < 2; u++) begin
            checks++;
            if (ack[u] !== 4'b0 || busy[u] !== 1'b0 ||
                gate_fault_in[u] !== 1'b0 || gate_in[u] !== 2'b0 ||
                ack_result[u] !== 1'b0) begin
               errors++;
               $display("FAIL reset u%0d c%0d: ack=%b busy=%b fault=%b gi=%b res=%b, want all 0",
                        u, c, ack[u], busy[u], gate_fault_in[u], gate_in[u], ack_result[u]);
            end
`ifdef FAULT_ARB_STATS_EN
            checks++;
            if (eval_count[u] !== 3'd0 || true_count[u] !== 3'd0) begin
               errors++;
               $display("FAIL reset_stats u%0d: eval=%0d true=%0d, want 0 0",
                        u, eval_count[u], true_count[u]);
            end
`endif
         end
      end
      req = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      lut[0] = 4'b1000;
      @(negedge clk);
      req[0] = 4'b0001;
      req_in[0] = {6'($urandom), 2'b11};
      @(negedge clk);
      checks++;
      if (gate_fault_in[0] !== 1'b1 || gate_in[0] !== 2'b11 ||
          ack[0] !== 4'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_issue: fault=%b gi=%b ack=%b busy=%b, want 1 11 0000 1",
                  gate_fault_in[0], gate_in[0], ack[0], busy[0]);
      end
      req_in[0] = 8'h00;
      @(negedge clk);
      checks++;
      if (gate_fault_in[0] !== 1'b0 || gate_in[0] !== 2'b11 || ack[0] !== 4'b0) begin
         errors++;
         $display("FAIL single_wait: fault=%b gi=%b ack=%b, want 0 11 0000",
                  gate_fault_in[0], gate_in[0], ack[0]);
      end
      @(negedge clk);
      checks++;
      if (ack[0] !== 4'b0001 || ack_result[0] !== 1'b1) begin
         errors++;
         $display("FAIL single_ack: ack=%b res=%b, want 0001 1", ack[0], ack_result[0]);
      end
      req[0] = 4'b0;
      @(negedge clk);
      checks++;
      if (ack[0] !== 4'b0 || busy[0] !== 1'b0 || gate_in[0] !== 2'b0) begin
         errors++;
         $display("FAIL single_idle: ack=%b busy=%b gi=%b, want 0000 0 00",
                  ack[0], busy[0], gate_in[0]);
      end
   endtask

   task automatic test_all_held();
      logic [3:0] a;
      int cyc;
      do_reset();
      lut[1] = 4'($urandom);
      @(negedge clk);
      req[1] = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_ack(1, 8, a, cyc);
         checks++;
         if (a !== 4'(1 << (n % 4)) || cyc != ((n == 0) ? 4 : 5)) begin
            errors++;
            $display("FAIL all_held n%0d: ack=%b after %0d, want %b after %0d",
                     n, a, cyc, 4'(1 << (n % 4)), (n == 0) ? 4 : 5);
         end
      end
      req[1] = 4'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_round_robin();
      logic [3:0] a;
      int cyc;
      do_reset();
      @(negedge clk);
      req[1] = 4'b0100;
      wait_ack(1, 8, a, cyc);
      checks++;
      if (a !== 4'b0100 || cyc != 4) begin
         errors++;
         $display("FAIL rr_first: ack=%b after %0d, want 0100 after 4", a, cyc);
      end
      req[1] = 4'b1010;
      wait_ack(1, 8, a, cyc);
      checks++;
      if (a !== 4'b1000 || cyc != 5) begin
         errors++;
         $display("FAIL rr_second: ack=%b after %0d, want 1000 after 5", a, cyc);
      end
      req[1] = 4'b0010;
      wait_ack(1, 8, a, cyc);
      checks++;
      if (a !== 4'b0010 || cyc != 5) begin
         errors++;
         $display("FAIL rr_third: ack=%b after %0d, want 0010 after 5", a, cyc);
      end
      req[1] = 4'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_abort();
      logic [3:0] a;
      int cyc;
      do_reset();
      @(negedge clk);
      req[1] = 4'b0100;
      repeat (2) @(negedge clk);
      checks++;
      if (busy[1] !== 1'b1 || gate_fault_in[1] !== 1'b0) begin
         errors++;
         $display("FAIL abort_wait: busy=%b fault=%b, want 1 0", busy[1], gate_fault_in[1]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy[1] !== 1'b0 || ack[1] !== 4'b0 || gate_fault_in[1] !== 1'b0 ||
          gate_in[1] !== 2'b0) begin
         errors++;
         $display("FAIL abort_async: busy=%b ack=%b fault=%b gi=%b, want all 0",
                  busy[1], ack[1], gate_fault_in[1], gate_in[1]);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (ack[1] !== 4'b0) begin
            errors++;
            $display("FAIL abort_noack c%0d: ack=%b, want 0000", c, ack[1]);
         end
      end
      rst_n = 1'b1;
      req[1] = 4'b1001;
      wait_ack(1, 8, a, cyc);
      checks++;
      if (a !== 4'b0001 || cyc != 4) begin
         errors++;
         $display("FAIL abort_first: ack=%b after %0d, want 0001 after 4", a, cyc);
      end
      req[1] = 4'b1000;
      wait_ack(1, 8, a, cyc);
      checks++;
      if (a !== 4'b1000 || cyc != 5) begin
         errors++;
         $display("FAIL abort_second: ack=%b after %0d, want 1000 after 5", a, cyc);
      end
      req[1] = 4'b0;
      repeat (6) @(negedge clk);
   endtask

   // Model: a grant at cycle g is a fixed schedule of pulse, wait and ack.
   task automatic test_random(input int u, input int ncyc);
      int L, g, d, m_ptr, m_idx;
      bit m_busy, chk_gi;
      logic [1:0] m_vec, e_gi;
      logic [3:0] e_ack, r;
      logic e_fault, e_busy;
      L = lat(u);
      g = 0;
      m_ptr = 3;
      m_idx = 0;
      m_busy = 1'b0;
      m_vec = '0;
      do_reset();
      lut[u] = 4'($urandom);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (m_busy && k - g >= L + 3) m_busy = 1'b0;
         d = k - g;
         if (m_busy) begin
            e_fault = (d == 1);
            e_ack = (d == L + 2) ? 4'(1 << m_idx) : 4'b0;
            e_gi = m_vec;
            chk_gi = (d != L + 2);
         end else begin
            e_fault = 1'b0;
            e_ack = 4'b0;
            e_gi = 2'b0;
            chk_gi = 1'b1;
         end
         e_busy = m_busy;
         checks++;
         if (ack[u] !== e_ack || busy[u] !== e_busy ||
             gate_fault_in[u] !== e_fault || (chk_gi && gate_in[u] !== e_gi)) begin
            errors++;
            $display("FAIL rand u%0d k%0d: ack=%b busy=%b fault=%b gi=%b, want %b %b %b %b",
                     u, k, ack[u], busy[u], gate_fault_in[u], gate_in[u],
                     e_ack, e_busy, e_fault, e_gi);
         end
         if (e_ack != 4'b0) begin
            checks++;
            if (ack_result[u] !== lut[u][m_vec]) begin
               errors++;
               $display("FAIL rand_result u%0d k%0d: res=%b, want %b",
                        u, k, ack_result[u], lut[u][m_vec]);
            end
         end
         r = req[u];
         for (int i = 0; i < 4; i++) begin
            if (m_busy && d == L + 2 && i == m_idx) r[i] = 1'($urandom_range(0, 1));
            else if (r[i]) r[i] = ($urandom_range(0, 9) != 0);
            else r[i] = ($urandom_range(0, 3) == 0);
         end
         req[u] = r;
         req_in[u] = 8'($urandom);
         if (!m_busy) begin
            for (int j = 1; j <= 4; j++) begin
               int c;
               c = (m_ptr + j) % 4;
               if (!m_busy && r[c]) begin
                  m_busy = 1'b1;
                  m_idx = c;
                  m_vec = req_in[u][c*2 +: 2];
                  m_ptr = c;
                  g = k;
               end
            end
         end
      end
      req[u] = 4'b0;
      repeat (6) @(negedge clk);
   endtask

`ifdef FAULT_ARB_STATS_EN
   task automatic test_stats();
      logic [3:0] a;
      int cyc, n_true;
      logic [1:0] v;
      do_reset();
      lut[0] = 4'b0001;
      n_true = 0;
      for (int n = 0; n < 14; n++) begin
         if (n < 5) v = (n == 0 || n == 1 || n == 3) ? 2'b00 : 2'b10;
         else v = 2'($urandom);
         if (v == 2'b00) n_true++;
         @(negedge clk);
         req[0] = 4'b0001;
         req_in[0] = {6'($urandom), v};
         wait_ack(0, 8, a, cyc);
         req[0] = 4'b0;
         checks++;
         if (a !== 4'b0001) begin
            errors++;
            $display("FAIL stats_ack n%0d: ack=%b, want 0001", n, a);
         end
         @(negedge clk);
         if (n == 4 || n == 13) begin
            checks++;
            if (eval_count[0] !== 3'((n + 1 > 7) ? 7 : n + 1) ||
                true_count[0] !== 3'((n_true > 7) ? 7 : n_true)) begin
               errors++;
               $display("FAIL stats n%0d: eval=%0d true=%0d, want %0d %0d",
                        n, eval_count[0], true_count[0],
                        (n + 1 > 7) ? 7 : n + 1, (n_true > 7) ? 7 : n_true);
            end
         end
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      req = '0;
      req_in = '0;
      lut = '0;
      test_reset();
      test_single();
      test_all_held();
      test_round_robin();
      test_abort();
      test_random(0, 400);
      test_random(1, 400);
`ifdef FAULT_ARB_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
